// File: rtl/gpr_wb_if.sv
// gpr_wb_if: writeback/issue bundle between EXU, LSU, IDU and the GPR writeback scheduler
// master: requesters (EXU/LSU writeback, IDU issue and source checks)
// slave: the scheduler (readies, busy flags, registered GPR write port)
interface gpr_wb_if #(
  parameter int AW = 5,
  parameter int DW = 64
);
  logic          exu_valid;
  logic          exu_ready;
  logic [AW-1:0] exu_rd;
  logic [DW-1:0] exu_data;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [AW-1:0] lsu_rd;
  logic [DW-1:0] lsu_data;
  logic          iss_valid;
  logic [AW-1:0] iss_rd;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic          rs1_busy;
  logic          rs2_busy;
  logic          rf_wen;
  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_wdata;
  modport master (
    output exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_rd, rs1, rs2,
    input  exu_ready, lsu_ready, rs1_busy, rs2_busy, rf_wen, rf_rd, rf_wdata
  );
  modport slave (
    input  exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data,
    input  iss_valid, iss_rd, rs1, rs2,
    output exu_ready, lsu_ready, rs1_busy, rs2_busy, rf_wen, rf_rd, rf_wdata
  );
endinterface

// File: rtl/gpr_wb_scheduler.sv
// gpr_wb_scheduler: round-robin EXU/LSU arbiter onto the single registered GPR write port, plus RAW scoreboard
// clk, rst  : clock and asynchronous active-high reset
// bus.exu_* : EXU writeback request (valid/ready/rd/data)
// bus.lsu_* : LSU load-return request (valid/ready/rd/data)
// bus.iss_* : IDU issue marks iss_rd pending; rs1/rs2 report busy
// bus.rf_*  : registered write port into register_file (x0 writes suppressed)
module gpr_wb_scheduler #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic     clk,
  input  logic     rst,
  gpr_wb_if.slave  bus
);
  typedef enum logic {LSU, EXU} src_t;
  src_t                   rr_ptr;
  logic [2**ADDR_WIDTH-1:0] pending;
  logic [2**ADDR_WIDTH-1:0] pending_nx;
  logic                   exu_go;
  logic                   lsu_go;
  assign bus.exu_ready = ~bus.lsu_valid | (rr_ptr == EXU);
  assign bus.lsu_ready = ~bus.exu_valid | (rr_ptr == LSU);
  assign exu_go        = bus.exu_valid & bus.exu_ready;
  assign lsu_go        = bus.lsu_valid & bus.lsu_ready;
  assign bus.rs1_busy  = pending[bus.rs1] & (bus.rs1 != '0);
  assign bus.rs2_busy  = pending[bus.rs2] & (bus.rs2 != '0);
  // Clear on commit first so a same-edge issue of the same register (the younger producer) wins.
  always_comb begin
    pending_nx = pending;
    if (bus.rf_wen) pending_nx[bus.rf_rd] = 1'b0;
    if (bus.iss_valid && bus.iss_rd != '0) pending_nx[bus.iss_rd] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= LSU;
      pending      <= '0;
      bus.rf_wen   <= 1'b0;
      bus.rf_rd    <= '0;
      bus.rf_wdata <= '0;
    end else begin
      pending    <= pending_nx;
      if (bus.exu_valid && bus.lsu_valid) rr_ptr <= (rr_ptr == LSU) ? EXU : LSU;
      // x0 transfers are accepted but never reach the register file.
      bus.rf_wen <= (exu_go && bus.exu_rd != '0) || (lsu_go && bus.lsu_rd != '0);
      if (exu_go || lsu_go) begin
        bus.rf_rd    <= exu_go ? bus.exu_rd : bus.lsu_rd;
        bus.rf_wdata <= exu_go ? bus.exu_data : bus.lsu_data;
      end
    end
  end
endmodule

// File: tb/tb_gpr_wb_scheduler.sv
// tb_gpr_wb_scheduler: model-checked directed bench for gpr_wb_scheduler
module tb_gpr_wb_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  gpr_wb_if #(.AW(5), .DW(64)) bus ();
  gpr_wb_scheduler #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // Reference state: expected registered port, pending set, and which source wins the next contention.
  bit          m_wen = 0;
  int          m_rd = 0;
  logic [63:0] m_data = 0;
  bit          m_pend [32];
  bit          m_lsu_next = 1;
  logic [4:0]  log_rd [$];
  logic [63:0] log_data [$];
  bit          grants [$];
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wen = 0; m_rd = 0; m_data = 0; m_lsu_next = 1;
      foreach (m_pend[i]) m_pend[i] = 0;
    end else begin
      bit lw, ew;
      lw = bus.lsu_valid && (!bus.exu_valid || m_lsu_next);
      ew = bus.exu_valid && (!bus.lsu_valid || !m_lsu_next);
      if (m_wen) m_pend[m_rd] = 0;
      if (bus.iss_valid && bus.iss_rd != 0) m_pend[bus.iss_rd] = 1;
      if (lw) begin m_wen = bus.lsu_rd != 0; m_rd = bus.lsu_rd; m_data = bus.lsu_data; end
      else if (ew) begin m_wen = bus.exu_rd != 0; m_rd = bus.exu_rd; m_data = bus.exu_data; end
      else m_wen = 0;
      if (bus.lsu_valid && bus.exu_valid) m_lsu_next = !m_lsu_next;
    end
  end
  always @(negedge clk) begin
    chk("exu_ready", bus.exu_ready, !bus.lsu_valid || !m_lsu_next);
    chk("lsu_ready", bus.lsu_ready, !bus.exu_valid || m_lsu_next);
    chk("rf_wen", bus.rf_wen, m_wen);
    if (m_wen) begin
      chk("rf_rd", bus.rf_rd, m_rd);
      chk("rf_wdata", bus.rf_wdata, m_data);
    end
    chk("rs1_busy", bus.rs1_busy, m_pend[bus.rs1] && bus.rs1 != 0);
    chk("rs2_busy", bus.rs2_busy, m_pend[bus.rs2] && bus.rs2 != 0);
    if (bus.rf_wen) begin log_rd.push_back(bus.rf_rd); log_data.push_back(bus.rf_wdata); end
    if (bus.lsu_valid && bus.lsu_ready) grants.push_back(1'b1);
    if (bus.exu_valid && bus.exu_ready) grants.push_back(1'b0);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int ei, li, n, k;
    int exp_rd [8];
    bus.exu_valid = 0; bus.exu_rd = 0; bus.exu_data = 0;
    bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
    bus.iss_valid = 0; bus.iss_rd = 0; bus.rs1 = 0; bus.rs2 = 0;
    #12 rst = 0;
    tick();
    chk("reset rf_wen", bus.rf_wen, 0);
    chk("reset rf_rd", bus.rf_rd, 0);
    chk("reset rf_wdata", bus.rf_wdata, 0);
    // Single LSU writeback.
    bus.lsu_valid = 1; bus.lsu_rd = 5; bus.lsu_data = 64'hAB;
    #1 chk("t1 lsu_ready", bus.lsu_ready, 1);
    tick();
    bus.lsu_valid = 0;
    chk("t1 rf_wen", bus.rf_wen, 1);
    chk("t1 rf_rd", bus.rf_rd, 5);
    chk("t1 rf_wdata", bus.rf_wdata, 64'hAB);
    tick();
    chk("t1 rf_wen low", bus.rf_wen, 0);
    // Continuous contention: EXU rd 1..4, LSU rd 11..14.
    log_rd.delete(); log_data.delete(); grants.delete();
    ei = 1; li = 11; n = 0;
    while ((ei <= 4 || li <= 14) && n < 30) begin
      bit ef, lf;
      bus.exu_valid = ei <= 4; bus.exu_rd = 5'(ei); bus.exu_data = 64'hD000 + 64'(ei);
      bus.lsu_valid = li <= 14; bus.lsu_rd = 5'(li); bus.lsu_data = 64'hD000 + 64'(li);
      #2;
      ef = bus.exu_valid && bus.exu_ready;
      lf = bus.lsu_valid && bus.lsu_ready;
      tick();
      if (ef) ei++;
      if (lf) li++;
      n++;
    end
    bus.exu_valid = 0; bus.lsu_valid = 0;
    chk("contention drained", n < 30, 1);
    tick(); tick();
    exp_rd = '{11, 1, 12, 2, 13, 3, 14, 4};
    chk("contention writes", log_rd.size(), 8);
    chk("contention grants", grants.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < log_rd.size()) begin
        chk("contention rd", log_rd[i], exp_rd[i]);
        chk("contention data", log_data[i], 64'hD000 + 64'(exp_rd[i]));
      end
      if (i < grants.size()) chk("grant order", grants[i], (i % 2) == 0);
    end
    // RAW on x7.
    bus.iss_valid = 1; bus.iss_rd = 7; bus.rs1 = 7;
    tick();
    bus.iss_valid = 0;
    chk("x7 busy after issue", bus.rs1_busy, 1);
    bus.exu_valid = 1; bus.exu_rd = 7; bus.exu_data = 64'h77;
    tick();
    bus.exu_valid = 0;
    chk("x7 rf_wen", bus.rf_wen, 1);
    chk("x7 busy during write", bus.rs1_busy, 1);
    tick();
    chk("x7 busy cleared", bus.rs1_busy, 0);
    // Same-edge set and clear on x9.
    bus.iss_valid = 1; bus.iss_rd = 9; bus.rs2 = 9;
    tick();
    bus.iss_valid = 0;
    bus.exu_valid = 1; bus.exu_rd = 9; bus.exu_data = 64'h99;
    tick();
    bus.exu_valid = 0;
    chk("x9 rf_wen", bus.rf_wen, 1);
    chk("x9 rf_rd", bus.rf_rd, 9);
    bus.iss_valid = 1; bus.iss_rd = 9;
    tick();
    bus.iss_valid = 0;
    chk("x9 set wins", bus.rs2_busy, 1);
    tick();
    chk("x9 still pending", bus.rs2_busy, 1);
    // x0 handling.
    bus.exu_valid = 1; bus.exu_rd = 0; bus.exu_data = 64'hFFFF;
    #1 chk("x0 exu_ready", bus.exu_ready, 1);
    tick();
    bus.exu_valid = 0;
    chk("x0 rf_wen", bus.rf_wen, 0);
    bus.iss_valid = 1; bus.iss_rd = 0; bus.rs1 = 0;
    tick();
    bus.iss_valid = 0;
    chk("x0 busy", bus.rs1_busy, 0);
    // Async reset mid-transfer with pending 3 and 4.
    bus.iss_valid = 1; bus.iss_rd = 3;
    tick();
    bus.iss_rd = 4;
    tick();
    bus.iss_valid = 0; bus.rs1 = 3; bus.rs2 = 4;
    #1 chk("x3 busy", bus.rs1_busy, 1);
    chk("x4 busy", bus.rs2_busy, 1);
    bus.lsu_valid = 1; bus.lsu_rd = 20; bus.lsu_data = 64'h2020;
    tick();
    chk("pre-reset rf_wen", bus.rf_wen, 1);
    #2 rst = 1;
    #1 chk("rst rf_wen", bus.rf_wen, 0);
    chk("rst rs1_busy", bus.rs1_busy, 0);
    chk("rst rs2_busy", bus.rs2_busy, 0);
    bus.exu_valid = 1; bus.exu_rd = 21; bus.exu_data = 64'h2121;
    tick();
    rst = 0;
    #1 chk("post-rst lsu_ready", bus.lsu_ready, 1);
    chk("post-rst exu_ready", bus.exu_ready, 0);
    tick();
    bus.lsu_valid = 0;
    chk("post-rst rf_rd", bus.rf_rd, 20);
    chk("post-rst rf_wdata", bus.rf_wdata, 64'h2020);
    k = 0;
    while (!(bus.exu_valid && bus.exu_ready) && k < 5) begin #1; k++; end
    chk("post-rst exu granted", bus.exu_ready, 1);
    tick();
    bus.exu_valid = 0;
    chk("post-rst exu rf_rd", bus.rf_rd, 21);
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
